// File: rtl/ebike_pkg.sv
// Shared types and constants for the e-bike pedal sensor chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ebike_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN} cad_state_t;

  localparam int          PER_W   = 8;
  localparam logic [7:0]  PER_MAX = 8'hFF;

  // Prescaler width: 9 bits for fast simulation, 16 bits for silicon.
  function automatic int pre_w(input int fast_sim);
    return (fast_sim != 0) ? 9 : 16;
  endfunction

endpackage

// File: rtl/cad_presc.sv
// Clearable free-running prescaler; tick marks the all-ones count.
// Latency: tick is decoded from the registered count (same cycle).
// Backpressure: none; clr forces the count to 0 on the next edge.
module cad_presc #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [W-1:0] cnt;

  // Count up every cycle, restarting from 0 whenever cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = &cnt;

endmodule

// File: rtl/cadence_meas.sv
// Measures rise-to-rise cadence period in prescaler ticks and flags pedaling.
// Latency: cadence_vld/cadence_per one cycle after the deciding cadence_rise or timeout tick.
// Backpressure: none; every cadence_rise strobe is accepted.
module cadence_meas
  import ebike_pkg::*;
#(
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cadence_rise,
  output logic [PER_W-1:0] cadence_per,
  output logic             cadence_vld,
  output logic             not_pedaling
);

  localparam int         PRE_W   = pre_w(FAST_SIM);
  // Counter value at which one more tick would saturate: the timeout point.
  localparam logic [7:0] PER_TMO = PER_MAX - 8'd1;

  cad_state_t       state;
  cad_state_t       state_nxt;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] per_cnt_nxt;
  logic [PER_W-1:0] per_nxt;
  logic             vld_nxt;
  logic             np_nxt;
  logic             clr;
  logic             tick;
  logic             tmo;

  cad_presc #(
    .W (PRE_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign tmo = tick && (per_cnt == PER_TMO);

  // Registered state, period counter and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      per_cnt      <= '0;
      cadence_per  <= PER_MAX;
      cadence_vld  <= 1'b0;
      not_pedaling <= 1'b1;
    end else begin
      state        <= state_nxt;
      per_cnt      <= per_cnt_nxt;
      cadence_per  <= per_nxt;
      cadence_vld  <= vld_nxt;
      not_pedaling <= np_nxt;
    end
  end

  // Next-state and output decode; a rise always takes priority over a timeout.
  always_comb begin
    state_nxt   = state;
    per_cnt_nxt = per_cnt;
    per_nxt     = cadence_per;
    vld_nxt     = 1'b0;
    np_nxt      = not_pedaling;
    clr         = 1'b0;

    if (tick && (per_cnt != PER_MAX)) begin
      per_cnt_nxt = per_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        // Counters parked at zero until the first edge arrives.
        clr         = 1'b1;
        per_cnt_nxt = '0;
        np_nxt      = 1'b1;
        if (cadence_rise) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        np_nxt = 1'b1;
        if (cadence_rise) begin
          per_nxt     = per_cnt;
          vld_nxt     = 1'b1;
          clr         = 1'b1;
          per_cnt_nxt = '0;
          np_nxt      = 1'b0;
          state_nxt   = RUN;
        end else if (tmo) begin
          // Second edge never came: fall back without reporting.
          per_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      RUN: begin
        if (cadence_rise) begin
          per_nxt     = per_cnt;
          vld_nxt     = 1'b1;
          clr         = 1'b1;
          per_cnt_nxt = '0;
          np_nxt      = 1'b0;
        end else if (tmo) begin
          // Pedaling stopped: publish a saturated period once and drop assist.
          per_nxt     = PER_MAX;
          vld_nxt     = 1'b1;
          np_nxt      = 1'b1;
          per_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        per_cnt_nxt = '0;
        np_nxt      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cadence_meas.sv
// Directed bench for cadence_meas with FAST_SIM=1 (tick every 512 clk).
// Latency: checks the one-cycle registered output timing cycle-exactly.
// Backpressure: n/a.
module tb_cadence_meas;

  logic       clk;
  logic       rst;
  logic       cadence_rise;
  logic [7:0] cadence_per;
  logic       cadence_vld;
  logic       not_pedaling;

  int vectors;
  int miscompares;

  cadence_meas #(
    .FAST_SIM (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cadence_rise (cadence_rise),
    .cadence_per  (cadence_per),
    .cadence_vld  (cadence_vld),
    .not_pedaling (not_pedaling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive cadence_rise for one clock edge; outputs are then sampled on the negedge.
  task automatic step(input logic r);
    cadence_rise = r;
    @(negedge clk);
    cadence_rise = 1'b0;
  endtask

  // Run n quiet cycles, counting vld pulses and not_pedaling levels seen.
  task automatic idle(input int n, output int vcnt, output int np_hi, output int np_lo);
    vcnt  = 0;
    np_hi = 0;
    np_lo = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      if (cadence_vld === 1'b1) vcnt++;
      if (not_pedaling === 1'b1) np_hi++;
      else np_lo++;
    end
  endtask

  int vc, nh, nl;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cadence_rise = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_per", 32'(cadence_per), 32'hFF);
    chk("rst_vld", 32'(cadence_vld), 32'h0);
    chk("rst_np",  32'(not_pedaling), 32'h1);
    rst = 1'b0;

    // 1: idle after reset
    idle(1000, vc, nh, nl);
    chk("idle_vld_cnt", 32'(vc), 32'd0);
    chk("idle_np_low",  32'(nl), 32'd0);
    chk("idle_per", 32'(cadence_per), 32'hFF);

    // 2: first rise arms silently, second after 10340 clk reports 20
    step(1'b1);
    chk("arm_vld", 32'(cadence_vld), 32'h0);
    chk("arm_np",  32'(not_pedaling), 32'h1);
    idle(10339, vc, nh, nl);
    chk("arm_wait_vld_cnt", 32'(vc), 32'd0);
    chk("arm_wait_np_low",  32'(nl), 32'd0);
    step(1'b1);
    chk("first_vld", 32'(cadence_vld), 32'h1);
    chk("first_per", 32'(cadence_per), 32'd20);
    chk("first_np",  32'(not_pedaling), 32'h0);

    // 3: steady 5220 clk cadence reports 10 each time
    for (int k = 0; k < 3; k++) begin
      idle(5219, vc, nh, nl);
      chk("steady_vld_cnt", 32'(vc), 32'd0);
      chk("steady_np_high", 32'(nh), 32'd0);
      step(1'b1);
      chk("steady_vld", 32'(cadence_vld), 32'h1);
      chk("steady_per", 32'(cadence_per), 32'd10);
      chk("steady_np",  32'(not_pedaling), 32'h0);
    end

    // 4: timeout 130560 clk after the last rise, single saturated report
    idle(130559, vc, nh, nl);
    chk("tmo_wait_vld_cnt", 32'(vc), 32'd0);
    chk("tmo_wait_np_high", 32'(nh), 32'd0);
    step(1'b0);
    chk("tmo_vld", 32'(cadence_vld), 32'h1);
    chk("tmo_per", 32'(cadence_per), 32'hFF);
    chk("tmo_np",  32'(not_pedaling), 32'h1);
    step(1'b0);
    chk("tmo_vld_single", 32'(cadence_vld), 32'h0);
    // Back in IDLE: next rise only arms
    step(1'b1);
    chk("post_tmo_idle_vld", 32'(cadence_vld), 32'h0);
    chk("post_tmo_idle_np",  32'(not_pedaling), 32'h1);

    // 5: rise lands on the timeout tick; rise wins, latches FE, enters RUN
    idle(130559, vc, nh, nl);
    chk("coin_wait_vld_cnt", 32'(vc), 32'd0);
    step(1'b1);
    chk("coin_vld", 32'(cadence_vld), 32'h1);
    chk("coin_per", 32'(cadence_per), 32'hFE);
    chk("coin_np",  32'(not_pedaling), 32'h0);
    idle(100, vc, nh, nl);
    chk("coin_run_np_high", 32'(nh), 32'd0);
    chk("coin_run_vld_cnt", 32'(vc), 32'd0);

    // 6: reset mid-interval in RUN discards the interval
    idle(1900, vc, nh, nl);
    rst = 1'b1;
    #1;
    chk("midrst_per", 32'(cadence_per), 32'hFF);
    chk("midrst_np",  32'(not_pedaling), 32'h1);
    @(negedge clk);
    chk("midrst_vld", 32'(cadence_vld), 32'h0);
    rst = 1'b0;
    step(1'b1);
    chk("rearm_vld", 32'(cadence_vld), 32'h0);
    chk("rearm_np",  32'(not_pedaling), 32'h1);
    idle(1999, vc, nh, nl);
    chk("rearm_wait_vld_cnt", 32'(vc), 32'd0);
    step(1'b1);
    chk("rearm_vld2", 32'(cadence_vld), 32'h1);
    chk("rearm_per",  32'(cadence_per), 32'd3);
    chk("rearm_np2",  32'(not_pedaling), 32'h0);

    // Back-to-back rise latches zero
    step(1'b1);
    chk("b2b_vld", 32'(cadence_vld), 32'h1);
    chk("b2b_per", 32'(cadence_per), 32'd0);
    step(1'b0);
    chk("b2b_vld_drop", 32'(cadence_vld), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cadence_meas.md
# cadence_meas

Controller that sequences cadence-period measurement for the e-bike pedal sensor chain. It consumes the single-cycle `cadence_rise` strobe from the cadence filter, times the interval between rises with a prescaled counter, and publishes a registered period plus a pedaling/not-pedaling status. Downstream it feeds the assist/torque computation, which uses `cadence_per` as its cadence term and `not_pedaling` as its assist gate.

## Interface
- `FAST_SIM`, default 0: selects the prescaler width. 0 means 16 bits (a tick every 65536 clk). 1 means 9 bits (a tick every 512 clk), for simulation.
- `clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: asynchronous, active-high reset.
- `cadence_rise`, in, 1: one-cycle strobe marking a filtered cadence rising edge.
- `cadence_per`, out, 8: last measured period, in prescaler ticks. Saturates at 8'hFF.
- `cadence_vld`, out, 1: one-cycle strobe; `cadence_per` was updated on this cycle.
- `not_pedaling`, out, 1: high when no valid cadence is present.

## Operation
- **Prescaler.** Free-running up-counter of width PRE_W (16 or 9).
  - `tick` is asserted when all PRE_W bits are 1.
  - The prescaler clears to 0 on any cycle where `cadence_rise` is accepted.
- **Period counter** `per_cnt` (8 bits).
  - Increments on `tick`.
  - Saturates at 8'hFF and never wraps.
  - Clears to 0 with the prescaler.
- **States:** IDLE, ARM, RUN.
- **IDLE.**
  - `not_pedaling`=1; counters are held at 0.
  - On `cadence_rise`: clear counters and go to ARM. No `cadence_vld` is issued.
- **ARM** (first edge seen; interval not yet complete).
  - `not_pedaling` stays 1.
  - On `cadence_rise`: `cadence_per` <= `per_cnt`, pulse `cadence_vld`, clear counters, go to RUN.
  - On `tick` with `per_cnt`==8'hFE (so the counter would reach 8'hFF): go to IDLE silently.
- **RUN.**
  - `not_pedaling`=0.
  - On `cadence_rise`: latch `cadence_per` <= `per_cnt`, pulse `cadence_vld`, clear counters, stay in RUN.
  - On `tick` with `per_cnt`==8'hFE (timeout): `cadence_per` <= 8'hFF, pulse `cadence_vld` once, `not_pedaling` <= 1, go to IDLE.
- **Simultaneous `cadence_rise` and timeout tick:** `cadence_rise` wins. The value latched is the pre-increment `per_cnt` (8'hFE), and the state stays RUN (or ARM→RUN).
- **Back-to-back rises** (consecutive cycles): each is accepted. The second latches `per_cnt`=0.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). Any pending interval is discarded.

## Timing
- Reset values: `cadence_per`=8'hFF, `cadence_vld`=0, `not_pedaling`=1, state IDLE, prescaler 0, `per_cnt` 0.
- All outputs are registered.
- `cadence_vld` and the new `cadence_per` appear the cycle after the `cadence_rise` cycle (1-cycle latency).
- `not_pedaling` falls in the same cycle `cadence_vld` first rises in RUN.
- For a rise-to-rise interval of N clk, `cadence_per` = min(floor((N-1)/2^PRE_W), 8'hFE).
- Timeout fires 255·2^PRE_W clk after the last accepted rise.
  - FAST_SIM=1: 130560 clk.
  - FAST_SIM=0: about 0.334 s at 50 MHz.
- `cadence_vld` is never high for two consecutive cycles unless `cadence_rise` arrives on consecutive cycles.

## Structure
- Shared package `ebike_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARM, RUN} cad_state_t`
  - `localparam PER_W = 8`
  - `localparam PER_MAX = 8'hFF`
  - function `pre_w(FAST_SIM)` returning 16 or 9.
- One sub-module, `cad_presc`: a parameterized-width clearable prescaler producing `tick`.
- State register, period counter and output registers live in `cadence_meas`.

## Test plan
All scenarios run with FAST_SIM=1 (tick every 512 clk).
1. Reset, then idle 1000 clk -> `cadence_per`=8'hFF, `not_pedaling`=1, `cadence_vld` never asserted.
2. Rises at t0 and t0+10340 -> no `cadence_vld` at t0+1; `cadence_vld`=1 at t0+10341 with `cadence_per`=20; `not_pedaling` falls at the same cycle.
3. Steady rises every 5220 clk in RUN -> each `cadence_vld` carries `cadence_per`=10; `not_pedaling` stays 0.
4. In RUN, stop rises -> exactly 130560 clk after the last rise, a single `cadence_vld` with `cadence_per`=8'hFF; `not_pedaling`=1; state IDLE.
5. Rise coincident with the timeout tick (interval 130560) -> `cadence_per`=8'hFE, state stays RUN, `not_pedaling` stays 0.
6. Assert `rst` mid-interval in RUN, release, then a single rise -> outputs at reset values and state ARM; `cadence_vld` appears only after the second rise.
